job_controller: RTL

//  Parametrised CAPI AFU job-control engine. Decodes PSL job commands (RESET/START),

---
 rtl/job_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/job_controller.sv
// CAPI AFU job-control engine: decodes PSL RESET/START commands, runs the
// running/done/error handshake, watchdog and saturating cycle counter.
module job_controller #(
  parameter int DONE_DELAY = 1,
  parameter int TIMEOUT    = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [7:0]       job_command,
  input  logic [63:0]      job_address,
  input  logic             work_done,
  input  logic             work_error,
  output logic             work_start,
  output logic [63:0]      wed_address,
  output logic             job_running,
  output logic             job_done,
  output logic [63:0]      job_error,
  output logic [CNT_W-1:0] job_cycles,
  output logic             cmd_dropped
);

  localparam logic [7:0] CMD_RESET = 8'h80;
  localparam logic [7:0] CMD_START = 8'h90;

  typedef enum logic [1:0] {IDLE, RUNNING, FINISH} state_t;

  state_t      state, state_nxt;
  logic        is_reset, is_start;
  logic        timeout_hit;
  logic        enq_valid;
  logic [63:0] enq_code;
  logic        accept, drop;
  logic        pend_valid;
  logic [63:0] pend_code;
  logic [DONE_DELAY-1:0] pipe_v;
  logic [63:0]           pipe_c [DONE_DELAY];

  assign is_reset = job_valid && (job_command == CMD_RESET);
  assign is_start = job_valid && (job_command == CMD_START);

  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT != 0)
      timeout_hit = (64'(job_cycles) == 64'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    enq_valid = 1'b0;
    enq_code  = '0;
    accept    = 1'b0;
    drop      = 1'b0;
    if (is_reset) begin
      state_nxt = IDLE;
      enq_valid = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (is_start) begin
            state_nxt = RUNNING;
            accept    = 1'b1;
          end
        end
        RUNNING: begin
          drop = is_start;
          if (work_done) begin
            state_nxt = FINISH;
            enq_valid = 1'b1;
            enq_code  = work_error ? 64'h1 : 64'h0;
          end else if (timeout_hit) begin
            state_nxt = FINISH;
            enq_valid = 1'b1;
            enq_code  = 64'h2;
          end
        end
        FINISH: begin
          drop      = is_start;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The done decision is registered once (pend) before entering the
  // DONE_DELAY-stage pipe, giving the 1 + DONE_DELAY decision-to-pulse latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_code   <= '0;
      work_start  <= 1'b0;
      wed_address <= '0;
      job_cycles  <= '0;
      cmd_dropped <= 1'b0;
      pipe_v      <= '0;
      for (int unsigned k = 0; k < DONE_DELAY; k++)
        pipe_c[k] <= '0;
    end else begin
      state      <= state_nxt;
      pend_valid <= enq_valid;
      pend_code  <= enq_code;
      work_start <= accept;
      if (accept) begin
        wed_address <= job_address;
        job_cycles  <= '0;
        cmd_dropped <= 1'b0;
      end else begin
        if (state == RUNNING && !is_reset && job_cycles != '1)
          job_cycles <= job_cycles + 1'b1;
        if (drop)
          cmd_dropped <= 1'b1;
      end
      pipe_v[0] <= pend_valid;
      pipe_c[0] <= pend_code;
      for (int unsigned k = 1; k < DONE_DELAY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_c[k] <= pipe_c[k-1];
      end
    end
  end

  assign job_running = (state == RUNNING);
  assign job_done    = pipe_v[DONE_DELAY-1];
  assign job_error   = pipe_c[DONE_DELAY-1];

endmodule
